// File: rtl/pwm_output_stage_pkg.sv
// pwm_output_stage_pkg
// Shared definitions for the PWM output stage and its bench:
//   - default widths for the counter value and the dead-time setting
//   - the 3-bit state encoding of the output FSM
package pwm_output_stage_pkg;

  localparam int DEFAULT_BITWIDTH          = 8;
  localparam int DEFAULT_DEADTIME_BITWIDTH = 4;

  // The three "quiet" states (IDLE and both dead states) all drive the
  // half-bridge fully off; only HIGH_ON and LOW_ON drive a switch.
  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    HIGH_ON      = 3'd1,
    DEAD_TO_LOW  = 3'd2,
    LOW_ON       = 3'd3,
    DEAD_TO_HIGH = 3'd4
  } pwmState_e;

endpackage

// File: rtl/pwm_output_stage_deadtime_timer.sv
// pwm_output_stage_deadtime_timer
// Down-counter that times the all-off gap of a switchover.
// Ports:
//   clock, reset      - clock and asynchronous active-high reset
//   load_i            - strobe: load loadValue_i - 1
//   loadValue_i       - dead-time length in cycles (non-zero when loaded)
//   decrement_i       - count down by one while not yet expired
//   expired_o         - high when the count has reached zero
module pwm_output_stage_deadtime_timer
  import pwm_output_stage_pkg::*;
#(
  parameter int WIDTH = DEFAULT_DEADTIME_BITWIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] loadValue_i,
  input  logic             decrement_i,
  output logic             expired_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Loading D-1 makes the dead state last exactly D cycles: the state is
  // occupied for D-1 decrements plus the cycle in which the count reads 0.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = loadValue_i - WIDTH'(1);
    end else if (decrement_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == '0);

endmodule

// File: rtl/pwm_output_stage.sv
// pwm_output_stage
// Turns a running counter value into a complementary, dead-time protected
// PWM pair for a half-bridge. The compare threshold is shadowed and only
// refreshed while the counter is stopped or on a counter overflow rising
// edge, so a mid-period change never produces a partial pulse.
// Ports:
//   clock, reset                - shared clock, asynchronous active-high reset
//   enable_i                    - low forces the FSM to IDLE
//   counter_value_i             - running counter value
//   counter_overflow_i          - overflow level; rising edge = period boundary
//   counter_counting_i          - counter running flag; low forces IDLE
//   compare_value_i             - requested duty threshold
//   deadtime_i                  - dead-time length, sampled on dead-state entry
//   active_compare_value_o      - shadow threshold in use
//   pwm_high_o, pwm_low_o       - half-bridge drives, never both high
//   in_deadtime_o               - high in either dead state
module pwm_output_stage
  import pwm_output_stage_pkg::*;
#(
  parameter int BITWIDTH          = DEFAULT_BITWIDTH,
  parameter int DEADTIME_BITWIDTH = DEFAULT_DEADTIME_BITWIDTH
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable_i,
  input  logic [BITWIDTH-1:0]          counter_value_i,
  input  logic                         counter_overflow_i,
  input  logic                         counter_counting_i,
  input  logic [BITWIDTH-1:0]          compare_value_i,
  input  logic [DEADTIME_BITWIDTH-1:0] deadtime_i,
  output logic [BITWIDTH-1:0]          active_compare_value_o,
  output logic                         pwm_high_o,
  output logic                         pwm_low_o,
  output logic                         in_deadtime_o
);

  pwmState_e           state_q;
  pwmState_e           state_d;
  logic                overflowPrev_q;
  logic [BITWIDTH-1:0] activeCompare_q;
  logic [BITWIDTH-1:0] activeCompare_d;
  logic                overflowRise;
  logic                rawDemand;
  logic                timerLoad;
  logic                timerDecrement;
  logic                timerExpired;
  logic                zeroDeadtime;

  assign overflowRise = counter_overflow_i && !overflowPrev_q;
  assign rawDemand    = (counter_value_i < activeCompare_q);
  assign zeroDeadtime = (deadtime_i == '0);

  // Shadow threshold: follows the request freely while the counter is
  // stopped, otherwise only at the period boundary.
  always_comb begin
    activeCompare_d = activeCompare_q;
    if (!counter_counting_i || overflowRise) begin
      activeCompare_d = compare_value_i;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflowPrev_q  <= 1'b0;
      activeCompare_q <= '0;
      state_q         <= IDLE;
    end else begin
      overflowPrev_q  <= counter_overflow_i;
      activeCompare_q <= activeCompare_d;
      state_q         <= state_d;
    end
  end

  // Next-state logic. A reverted demand inside a dead state goes straight
  // back to the side that was on: that side never stopped being safe, so
  // no extra gap is needed, and the pending switchover restarts its full
  // dead time on the next attempt.
  always_comb begin
    state_d        = state_q;
    timerLoad      = 1'b0;
    timerDecrement = 1'b0;
    if (!enable_i || !counter_counting_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, LOW_ON: begin
          if (rawDemand) begin
            if (zeroDeadtime) begin
              state_d = HIGH_ON;
            end else begin
              state_d   = DEAD_TO_HIGH;
              timerLoad = 1'b1;
            end
          end else begin
            state_d = LOW_ON;
          end
        end
        HIGH_ON: begin
          if (!rawDemand) begin
            if (zeroDeadtime) begin
              state_d = LOW_ON;
            end else begin
              state_d   = DEAD_TO_LOW;
              timerLoad = 1'b1;
            end
          end
        end
        DEAD_TO_HIGH: begin
          if (!rawDemand) begin
            state_d = LOW_ON;
          end else if (timerExpired) begin
            state_d = HIGH_ON;
          end else begin
            timerDecrement = 1'b1;
          end
        end
        DEAD_TO_LOW: begin
          if (rawDemand) begin
            state_d = HIGH_ON;
          end else if (timerExpired) begin
            state_d = LOW_ON;
          end else begin
            timerDecrement = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  pwm_output_stage_deadtime_timer #(
    .WIDTH(DEADTIME_BITWIDTH)
  ) u_deadtimeTimer (
    .clock       (clock),
    .reset       (reset),
    .load_i      (timerLoad),
    .loadValue_i (deadtime_i),
    .decrement_i (timerDecrement),
    .expired_o   (timerExpired)
  );

  // Drives decode straight from the state register, so an asynchronous
  // reset turns both switches off without waiting for a clock.
  assign pwm_high_o             = (state_q == HIGH_ON);
  assign pwm_low_o              = (state_q == LOW_ON);
  assign in_deadtime_o          = (state_q == DEAD_TO_LOW) || (state_q == DEAD_TO_HIGH);
  assign active_compare_value_o = activeCompare_q;

endmodule

// File: tb/tb_pwm_output_stage.sv
// tb_pwm_output_stage
// Directed bench for pwm_output_stage. Inputs are driven 1 time unit after
// each rising edge and outputs are checked at that same point, i.e. they
// show the state registered at the edge that consumed the previous inputs.
// Observed outputs are packed as {in_deadtime, pwm_low, pwm_high}.
module tb_pwm_output_stage;
  import pwm_output_stage_pkg::*;

  localparam logic [2:0] OFF  = 3'b000;
  localparam logic [2:0] HIGH = 3'b001;
  localparam logic [2:0] LOW  = 3'b010;
  localparam logic [2:0] DEAD = 3'b100;

  logic       clock;
  logic       reset;
  logic       enable;
  logic [7:0] counterValue;
  logic       counterOverflow;
  logic       counterCounting;
  logic [7:0] compareValue;
  logic [3:0] deadtime;
  logic [7:0] activeCompare;
  logic       pwmHigh;
  logic       pwmLow;
  logic       inDeadtime;

  int testsRun  = 0;
  int failCount = 0;

  pwm_output_stage dut (
    .clock                  (clock),
    .reset                  (reset),
    .enable_i               (enable),
    .counter_value_i        (counterValue),
    .counter_overflow_i     (counterOverflow),
    .counter_counting_i     (counterCounting),
    .compare_value_i        (compareValue),
    .deadtime_i             (deadtime),
    .active_compare_value_o (activeCompare),
    .pwm_high_o             (pwmHigh),
    .pwm_low_o              (pwmLow),
    .in_deadtime_o          (inDeadtime)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    testsRun++;
    if ({inDeadtime, pwmLow, pwmHigh} !== OFF) begin
      failCount++;
      $display("[TB] FAIL reset_outputs: got %b expected %b", {inDeadtime, pwmLow, pwmHigh}, OFF);
    end
    testsRun++;
    if (activeCompare !== 8'd0) begin
      failCount++;
      $display("[TB] FAIL reset_compare: got %0d expected 0", activeCompare);
    end
    testsRun++;
    if (dut.state_q !== IDLE) begin
      failCount++;
      $display("[TB] FAIL reset_state: got %0d expected %0d", dut.state_q, IDLE);
    end
  endtask

  task automatic test_sweep_deadtime2();
    logic [7:0] valSeq [12] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd0, 8'd1, 8'd2, 8'd3};
    logic [2:0] expSeq [12] = '{DEAD, DEAD, HIGH, DEAD, DEAD, LOW, LOW, LOW, DEAD, DEAD, HIGH, DEAD};
    deadtime        = 4'd2;
    compareValue    = 8'd3;
    counterCounting = 1'b0;
    tick();
    counterCounting = 1'b1;
    for (int i = 0; i < 12; i++) begin
      counterValue = valSeq[i];
      tick();
      testsRun++;
      if ({inDeadtime, pwmLow, pwmHigh} !== expSeq[i]) begin
        failCount++;
        $display("[TB] FAIL sweep_dt2 step %0d: got %b expected %b", i, {inDeadtime, pwmLow, pwmHigh}, expSeq[i]);
      end
    end
  endtask

  task automatic test_shadow_load();
    int highCount = 0;
    compareValue = 8'd6;
    for (int v = 4; v < 8; v++) begin
      counterValue = 8'(v);
      tick();
      testsRun++;
      if (activeCompare !== 8'd3) begin
        failCount++;
        $display("[TB] FAIL shadow_hold v=%0d: got %0d expected 3", v, activeCompare);
      end
    end
    counterOverflow = 1'b1;
    counterValue    = 8'd0;
    tick();
    testsRun++;
    if (activeCompare !== 8'd6) begin
      failCount++;
      $display("[TB] FAIL shadow_load: got %0d expected 6", activeCompare);
    end
    for (int v = 1; v < 8; v++) begin
      if (v == 2) counterOverflow = 1'b0;
      counterValue = 8'(v);
      tick();
      if (pwmHigh) highCount++;
    end
    testsRun++;
    if (highCount != 4) begin
      failCount++;
      $display("[TB] FAIL shadow_wider_pulse: got %0d high cycles expected 4", highCount);
    end
  endtask

  task automatic test_zero_deadtime();
    logic [7:0] valSeq [11] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd0, 8'd1, 8'd2};
    logic [2:0] expSeq [11] = '{HIGH, HIGH, HIGH, HIGH, LOW, LOW, LOW, LOW, HIGH, HIGH, HIGH};
    deadtime        = 4'd0;
    compareValue    = 8'd4;
    counterCounting = 1'b0;
    tick();
    counterCounting = 1'b1;
    for (int i = 0; i < 11; i++) begin
      counterValue = valSeq[i];
      tick();
      testsRun++;
      if ({inDeadtime, pwmLow, pwmHigh} !== expSeq[i]) begin
        failCount++;
        $display("[TB] FAIL zero_dt step %0d: got %b expected %b", i, {inDeadtime, pwmLow, pwmHigh}, expSeq[i]);
      end
      testsRun++;
      if (pwmHigh && pwmLow) begin
        failCount++;
        $display("[TB] FAIL zero_dt_overlap step %0d: got both high expected at most one", i);
      end
    end
  endtask

  task automatic test_glitch_abort();
    deadtime        = 4'd5;
    compareValue    = 8'd4;
    counterCounting = 1'b0;
    tick();
    counterCounting = 1'b1;
    counterValue    = 8'd10;
    tick();
    testsRun++;
    if ({inDeadtime, pwmLow, pwmHigh} !== LOW) begin
      failCount++;
      $display("[TB] FAIL glitch_start: got %b expected %b", {inDeadtime, pwmLow, pwmHigh}, LOW);
    end
    counterValue = 8'd2;
    tick();
    testsRun++;
    if (dut.state_q !== DEAD_TO_HIGH) begin
      failCount++;
      $display("[TB] FAIL glitch_dead_state: got %0d expected %0d", dut.state_q, DEAD_TO_HIGH);
    end
    counterValue = 8'd10;
    for (int i = 0; i < 3; i++) begin
      tick();
      testsRun++;
      if ({inDeadtime, pwmLow, pwmHigh} !== LOW) begin
        failCount++;
        $display("[TB] FAIL glitch_return step %0d: got %b expected %b", i, {inDeadtime, pwmLow, pwmHigh}, LOW);
      end
    end
  endtask

  task automatic test_compare_extremes();
    logic [7:0] lowVals  [5] = '{8'd0, 8'd1, 8'd100, 8'd254, 8'd255};
    logic [7:0] highVals [5] = '{8'd0, 8'd1, 8'd2, 8'd100, 8'd254};
    logic [2:0] highExp  [5] = '{DEAD, DEAD, HIGH, HIGH, HIGH};
    deadtime        = 4'd2;
    compareValue    = 8'd0;
    counterCounting = 1'b0;
    tick();
    counterCounting = 1'b1;
    for (int i = 0; i < 5; i++) begin
      counterValue = lowVals[i];
      tick();
      testsRun++;
      if ({inDeadtime, pwmLow, pwmHigh} !== LOW) begin
        failCount++;
        $display("[TB] FAIL compare0 step %0d: got %b expected %b", i, {inDeadtime, pwmLow, pwmHigh}, LOW);
      end
    end
    compareValue    = 8'd255;
    counterCounting = 1'b0;
    tick();
    counterCounting = 1'b1;
    for (int i = 0; i < 5; i++) begin
      counterValue = highVals[i];
      tick();
      testsRun++;
      if ({inDeadtime, pwmLow, pwmHigh} !== highExp[i]) begin
        failCount++;
        $display("[TB] FAIL compare255 step %0d: got %b expected %b", i, {inDeadtime, pwmLow, pwmHigh}, highExp[i]);
      end
    end
  endtask

  task automatic test_reset_and_disable();
    // Still in HIGH_ON from the previous scenario; reset lands mid-cycle.
    #2;
    reset = 1'b1;
    #1;
    testsRun++;
    if ({inDeadtime, pwmLow, pwmHigh} !== OFF) begin
      failCount++;
      $display("[TB] FAIL async_reset_outputs: got %b expected %b", {inDeadtime, pwmLow, pwmHigh}, OFF);
    end
    testsRun++;
    if (activeCompare !== 8'd0) begin
      failCount++;
      $display("[TB] FAIL async_reset_compare: got %0d expected 0", activeCompare);
    end
    @(negedge clock);
    reset = 1'b0;
    #1;
    testsRun++;
    if (dut.state_q !== IDLE) begin
      failCount++;
      $display("[TB] FAIL reset_release_state: got %0d expected %0d", dut.state_q, IDLE);
    end
    deadtime        = 4'd3;
    compareValue    = 8'd255;
    counterCounting = 1'b0;
    tick();
    counterCounting = 1'b1;
    for (int v = 0; v < 4; v++) begin
      counterValue = 8'(v);
      tick();
    end
    testsRun++;
    if ({inDeadtime, pwmLow, pwmHigh} !== HIGH) begin
      failCount++;
      $display("[TB] FAIL dt3_reach_high: got %b expected %b", {inDeadtime, pwmLow, pwmHigh}, HIGH);
    end
    counterValue = 8'd255;
    tick();
    testsRun++;
    if (dut.state_q !== DEAD_TO_LOW) begin
      failCount++;
      $display("[TB] FAIL enter_dead_to_low: got %0d expected %0d", dut.state_q, DEAD_TO_LOW);
    end
    enable = 1'b0;
    tick();
    testsRun++;
    if ({inDeadtime, pwmLow, pwmHigh} !== OFF) begin
      failCount++;
      $display("[TB] FAIL disable_outputs: got %b expected %b", {inDeadtime, pwmLow, pwmHigh}, OFF);
    end
    testsRun++;
    if (dut.state_q !== IDLE) begin
      failCount++;
      $display("[TB] FAIL disable_state: got %0d expected %0d", dut.state_q, IDLE);
    end
  endtask

  initial begin
    reset           = 1'b1;
    enable          = 1'b1;
    counterValue    = 8'd0;
    counterOverflow = 1'b0;
    counterCounting = 1'b0;
    compareValue    = 8'd0;
    deadtime        = 4'd0;
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    @(negedge clock);
    reset = 1'b0;
    test_sweep_deadtime2();
    test_shadow_load();
    test_zero_deadtime();
    test_glitch_abort();
    test_compare_extremes();
    test_reset_and_disable();
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
